// File: rtl/game_turn_controller.sv
// Two-player memory game sequencer. It alternates turns, reloads and enables the
// game timer, checks each key against the pattern memory, keeps scores and names the winner.
module game_turn_controller #(
  parameter int SEQ_MAX = 8,
  parameter int ROUNDS  = 3,
  parameter int SCORE_W = 4,
  localparam int AW = (SEQ_MAX > 1) ? $clog2(SEQ_MAX) : 1,
  localparam int LW = $clog2(SEQ_MAX + 1),
  localparam int RW = $clog2(ROUNDS + 1)
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Start,
  input  logic [3:0]         Seq_Len,
  input  logic [3:0]         Key_P1,
  input  logic               Key_P1_Valid,
  input  logic [3:0]         Key_P2,
  input  logic               Key_P2_Valid,
  output logic [AW-1:0]      Pattern_Addr,
  input  logic [3:0]         Pattern_Data,
  input  logic               Timer_Stop,
  output logic               Timer_Load,
  output logic               Timer_En,
  output logic               Active_Player,
  output logic [SCORE_W-1:0] Score1,
  output logic [SCORE_W-1:0] Score2,
  output logic               Match_Pulse,
  output logic               Miss_Pulse,
  output logic               Game_Over,
  output logic [1:0]         Winner
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ARM, S_WAIT, S_SWAP, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [LW-1:0]      len_q, len_d;
  logic [RW-1:0]      round_q, round_d;
  logic               active_q, active_d;
  logic [SCORE_W-1:0] s1_q, s1_d, s2_q, s2_d;
  logic               load_q, load_d, en_q, en_d;
  logic               match_q, match_d, miss_q, miss_d;
  logic               over_q, over_d;
  logic [1:0]         winner_q, winner_d;

  logic [LW-1:0] len_in;
  logic [3:0]    key;
  logic          key_vld;
  logic          last_sym;

  always_comb begin
    if (Seq_Len == 4'd0)               len_in = LW'(1);
    else if (int'(Seq_Len) > SEQ_MAX)  len_in = LW'(SEQ_MAX);
    else                               len_in = LW'(Seq_Len);
  end

  // Only the active player's keypad is looked at; the other one is simply not selected.
  assign key      = active_q ? Key_P2 : Key_P1;
  assign key_vld  = active_q ? Key_P2_Valid : Key_P1_Valid;
  assign last_sym = (LW'(idx_q) == len_q - LW'(1));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_d    = len_q;
    round_d  = round_q;
    active_d = active_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    match_d  = 1'b0;
    miss_d   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          len_d    = len_in;
          s1_d     = '0;
          s2_d     = '0;
          round_d  = '0;
          active_d = 1'b0;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        idx_d   = '0;
        state_d = S_ARM;
      end
      S_ARM: state_d = S_WAIT;
      S_WAIT: begin
        // A timeout beats a key arriving in the same cycle.
        if (Timer_Stop) begin
          miss_d  = 1'b1;
          state_d = S_SWAP;
        end else if (key_vld) begin
          if (key == Pattern_Data) begin
            if (last_sym) begin
              if (active_q) s2_d = (s2_q == '1) ? s2_q : s2_q + 1'b1;
              else          s1_d = (s1_q == '1) ? s1_q : s1_q + 1'b1;
              match_d = 1'b1;
              state_d = S_SWAP;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            miss_d  = 1'b1;
            state_d = S_SWAP;
          end
        end
      end
      S_SWAP: begin
        if (active_q) round_d = round_q + 1'b1;
        active_d = ~active_q;
        state_d  = (round_d == RW'(ROUNDS)) ? S_DONE : S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    load_d = (state_d == S_LOAD);
    en_d   = (state_d == S_ARM) || (state_d == S_WAIT);
    over_d = (state_d == S_DONE);
    if (!over_d)          winner_d = 2'b00;
    else if (s1_d > s2_d) winner_d = 2'b01;
    else if (s2_d > s1_d) winner_d = 2'b10;
    else                  winner_d = 2'b11;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      len_q    <= LW'(1);
      round_q  <= '0;
      active_q <= 1'b0;
      s1_q     <= '0;
      s2_q     <= '0;
      load_q   <= 1'b0;
      en_q     <= 1'b0;
      match_q  <= 1'b0;
      miss_q   <= 1'b0;
      over_q   <= 1'b0;
      winner_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      round_q  <= round_d;
      active_q <= active_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      load_q   <= load_d;
      en_q     <= en_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      over_q   <= over_d;
      winner_q <= winner_d;
    end
  end

  assign Pattern_Addr  = idx_q;
  assign Timer_Load    = load_q;
  assign Timer_En      = en_q;
  assign Active_Player = active_q;
  assign Score1        = s1_q;
  assign Score2        = s2_q;
  assign Match_Pulse   = match_q;
  assign Miss_Pulse    = miss_q;
  assign Game_Over     = over_q;
  assign Winner        = winner_q;

endmodule

// File: tb/tb_game_turn_controller.sv
// Randomized bench for game_turn_controller: a turn-level game model pushes expected
// pulses and game results into a scoreboard that a negedge monitor drains.
module tb_game_turn_controller;
  localparam int SEQ_MAX = 8;
  localparam int ROUNDS  = 4;
  localparam int SCORE_W = 2;
  localparam int AW      = $clog2(SEQ_MAX);
  localparam int SMAX    = (1 << SCORE_W) - 1;

  logic Clk = 1'b0, Rst = 1'b1, Start = 1'b0, Timer_Stop = 1'b0;
  logic [3:0] Seq_Len = '0, Key_P1 = '0, Key_P2 = '0, Pattern_Data;
  logic Key_P1_Valid = 1'b0, Key_P2_Valid = 1'b0;
  logic [AW-1:0] Pattern_Addr;
  logic Timer_Load, Timer_En, Active_Player, Match_Pulse, Miss_Pulse, Game_Over;
  logic [SCORE_W-1:0] Score1, Score2;
  logic [1:0] Winner;

  logic [3:0] pat [SEQ_MAX];
  assign Pattern_Data = pat[Pattern_Addr];

  game_turn_controller #(.SEQ_MAX(SEQ_MAX), .ROUNDS(ROUNDS), .SCORE_W(SCORE_W)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Seq_Len(Seq_Len),
    .Key_P1(Key_P1), .Key_P1_Valid(Key_P1_Valid), .Key_P2(Key_P2), .Key_P2_Valid(Key_P2_Valid),
    .Pattern_Addr(Pattern_Addr), .Pattern_Data(Pattern_Data), .Timer_Stop(Timer_Stop),
    .Timer_Load(Timer_Load), .Timer_En(Timer_En), .Active_Player(Active_Player),
    .Score1(Score1), .Score2(Score2), .Match_Pulse(Match_Pulse), .Miss_Pulse(Miss_Pulse),
    .Game_Over(Game_Over), .Winner(Winner));

  always #5 Clk = ~Clk;

  int checks = 0, errors = 0;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // kind: 0 = match pulse, 1 = miss pulse, 2 = game over
  typedef struct { int kind; int player; int s1; int s2; int win; } exp_t;
  exp_t sbq[$];

  // Game model: scores, round, whose turn, how far into the pattern.
  int m_s[2];
  int m_round, m_active, m_len, m_idx;
  bit m_over = 1'b1;

  function automatic void m_start(int l);
    m_len = (l == 0) ? 1 : (l > SEQ_MAX ? SEQ_MAX : l);
    m_s[0] = 0; m_s[1] = 0;
    m_round = 0; m_active = 0; m_idx = 0; m_over = 1'b0;
  endfunction

  function automatic void m_end_turn(int kind);
    exp_t e;
    e = '{kind, m_active, m_s[0], m_s[1], 0};
    sbq.push_back(e);
    m_idx = 0;
    if (m_active == 1) m_round++;
    m_active = 1 - m_active;
    if (m_round == ROUNDS) begin
      m_over = 1'b1;
      e = '{2, 0, m_s[0], m_s[1], (m_s[0] > m_s[1]) ? 1 : (m_s[1] > m_s[0]) ? 2 : 3};
      sbq.push_back(e);
    end
  endfunction

  function automatic void m_step(int who, bit vld, int key, bit stop);
    if (m_over) return;
    if (stop) begin m_end_turn(1); return; end
    if (!vld || who != m_active) return;
    if (key == int'(pat[m_idx])) begin
      if (m_idx == m_len - 1) begin
        if (m_s[m_active] < SMAX) m_s[m_active]++;
        m_end_turn(0);
      end else m_idx++;
    end else m_end_turn(1);
  endfunction

  // Monitor: drains the scoreboard on every pulse / game-over edge.
  int  loads = 0;
  bit  prev_over = 1'b0;
  always @(negedge Clk) begin
    exp_t e;
    if (Rst) begin
      loads = 0;
      prev_over = 1'b0;
    end else begin
      if (Timer_Load) begin
        loads++;
        check("load_vs_en", int'(Timer_En), 0);
      end
      if (Match_Pulse || Miss_Pulse) begin
        check("pulse_exclusive", int'(Match_Pulse && Miss_Pulse), 0);
        check("loads_per_turn", loads, 1);
        loads = 0;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: match=%0d miss=%0d with empty scoreboard", Match_Pulse, Miss_Pulse);
        end else begin
          e = sbq.pop_front();
          check("pulse_kind_match", int'(Match_Pulse), int'(e.kind == 0));
          check("pulse_kind_miss", int'(Miss_Pulse), int'(e.kind == 1));
          check("pulse_player", int'(Active_Player), e.player);
          check("score1", int'(Score1), e.s1);
          check("score2", int'(Score2), e.s2);
        end
      end
      if (Game_Over && !prev_over) begin
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_game_over: winner=%0d with empty scoreboard", Winner);
        end else begin
          e = sbq.pop_front();
          check("over_kind", 2, e.kind);
          check("winner", int'(Winner), e.win);
          check("over_timer_en", int'(Timer_En), 0);
          check("over_score1", int'(Score1), e.s1);
          check("over_score2", int'(Score2), e.s2);
        end
      end
      prev_over = Game_Over;
    end
  end

  // All drives happen at posedge+1.
  task automatic drive(int who, bit vld, int key, bit stop);
    if (vld && !stop && who == m_active) check("pattern_addr", int'(Pattern_Addr), m_idx);
    if (who == 0) begin Key_P1 = 4'(key); Key_P1_Valid = vld; end
    else          begin Key_P2 = 4'(key); Key_P2_Valid = vld; end
    Timer_Stop = stop;
    @(posedge Clk);
    m_step(who, vld, key, stop);
    #1;
    Key_P1_Valid = 1'b0; Key_P2_Valid = 1'b0; Timer_Stop = 1'b0;
  endtask

  task automatic wait_turn(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge Clk);
      if (Timer_Load) ok = 1'b1;
    end
    if (!ok) begin
      errors++;
      $display("FAIL turn_timeout: no Timer_Load within 30 cycles");
      @(posedge Clk); #1;
    end else begin
      @(posedge Clk); @(posedge Clk); #1;
      check("en_in_wait", int'(Timer_En), 1);
    end
  endtask

  task automatic body(int kind);
    int a, n;
    a = m_active;
    case (kind)
      0: for (int i = 0; i < m_len; i++) begin
           if ($urandom_range(0, 3) == 0) drive(1 - a, 1'b1, int'($urandom_range(0, 15)), 1'b0);
           drive(a, 1'b1, int'(pat[m_idx]), 1'b0);
         end
      1, 2: begin
        n = int'($urandom_range(0, m_len - 1));
        for (int i = 0; i < n; i++) drive(a, 1'b1, int'(pat[m_idx]), 1'b0);
        if (kind == 1) drive(a, 1'b1, int'(pat[m_idx]) ^ int'($urandom_range(1, 15)), 1'b0);
        else           drive(a, 1'b0, 0, 1'b1);
      end
      default: begin
        for (int i = 0; i < m_len - 1; i++) drive(a, 1'b1, int'(pat[m_idx]), 1'b0);
        drive(a, 1'b1, int'(pat[m_idx]), 1'b1);
      end
    endcase
  endtask

  task automatic play(int kind);
    bit ok;
    wait_turn(ok);
    if (ok) body(kind);
  endtask

  task automatic start_game(int l, bit rnd);
    if (rnd) for (int i = 0; i < SEQ_MAX; i++) pat[i] = 4'($urandom_range(0, 15));
    Start = 1'b1; Seq_Len = 4'(l);
    @(posedge Clk);
    m_start(l);
    #1;
    Start = 1'b0;
    check("start_score1", int'(Score1), 0);
    check("start_score2", int'(Score2), 0);
    check("start_over", int'(Game_Over), 0);
    check("start_load", int'(Timer_Load), 1);
  endtask

  task automatic wait_over();
    bit seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge Clk);
      if (Game_Over) seen = 1'b1;
    end
    if (!seen) begin errors++; $display("FAIL game_over_timeout: Game_Over never rose"); end
    @(posedge Clk); #1;
  endtask

  int g1[8] = '{0, 1, 2, 3, 0, 0, 1, 0};

  initial begin
    bit ok;
    for (int i = 0; i < SEQ_MAX; i++) pat[i] = 4'(i);
    @(posedge Clk); #1;
    check("rst_load", int'(Timer_Load), 0);
    check("rst_en", int'(Timer_En), 0);
    check("rst_over", int'(Game_Over), 0);
    check("rst_winner", int'(Winner), 0);
    check("rst_match", int'(Match_Pulse), 0);
    check("rst_miss", int'(Miss_Pulse), 0);
    @(posedge Clk); #1;
    Rst = 1'b0;

    // Game 1: pattern 5,2,9; P1 and P2 each complete two turns -> tie.
    pat[0] = 4'd5; pat[1] = 4'd2; pat[2] = 4'd9;
    start_game(3, 1'b0);
    foreach (g1[i]) play(g1[i]);
    wait_over();

    // Start from DONE with Seq_Len=0: single-key turns.
    start_game(0, 1'b1);
    for (int t = 0; t < 2 * ROUNDS; t++) play(int'($urandom_range(0, 3)));
    wait_over();

    // Seq_Len above SEQ_MAX: eight keys, P1 wins every turn and saturates.
    start_game(12, 1'b1);
    for (int t = 0; t < 2 * ROUNDS; t++) play((m_active == 0) ? 0 : int'($urandom_range(1, 3)));
    wait_over();

    for (int g = 0; g < 3; g++) begin
      start_game(int'($urandom_range(0, 15)), 1'b1);
      for (int t = 0; t < 2 * ROUNDS; t++) play(int'($urandom_range(0, 3)));
      wait_over();
    end

    // Reset while P2 is two symbols into the pattern.
    start_game(5, 1'b1);
    play(0);
    wait_turn(ok);
    drive(1, 1'b1, int'(pat[0]), 1'b0);
    drive(1, 1'b1, int'(pat[1]), 1'b0);
    check("pre_rst_idx", int'(Pattern_Addr), 2);
    Rst = 1'b1;
    @(posedge Clk); #1;
    sbq.delete();
    m_over = 1'b1;
    check("mid_rst_addr", int'(Pattern_Addr), 0);
    check("mid_rst_player", int'(Active_Player), 0);
    check("mid_rst_score1", int'(Score1), 0);
    check("mid_rst_en", int'(Timer_En), 0);
    check("mid_rst_load", int'(Timer_Load), 0);
    check("mid_rst_over", int'(Game_Over), 0);
    Rst = 1'b0;

    // Start during WAIT_KEY must not restart the game or change the length.
    start_game(4, 1'b1);
    wait_turn(ok);
    Start = 1'b1; Seq_Len = 4'd1;
    @(posedge Clk); #1;
    Start = 1'b0;
    check("start_ignored_load", int'(Timer_Load), 0);
    check("start_ignored_en", int'(Timer_En), 1);
    body(0);
    play(0);

    repeat (4) @(posedge Clk);
    #1;
    check("scoreboard_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end
endmodule
